// File: rtl/seq_detect_param.sv
// Runtime-configurable serial bit-sequence detector.
// Registered match pulse plus saturating match counter.
module seq_detect_param #(
  parameter int                   MAX_LEN         = 8,
  parameter int                   LEN_W           = 4,
  parameter int                   CNT_W           = 8,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = 8'b0001_0110,
  parameter int                   DEFAULT_LEN     = 5,
  parameter bit                   DEFAULT_OVERLAP = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DLEN =
    (DEFAULT_LEN > MAX_LEN) ? MAXL : LEN_W'(DEFAULT_LEN);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_c;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_n;
  logic               ovl;
  logic               hit;
  logic               cnt_hit;

  always_comb begin
    len_c  = (cfg_len > MAXL) ? MAXL : cfg_len;
    fill_n = (fill >= MAXL) ? MAXL : fill + LEN_W'(1);
    hist_n = {hist[MAX_LEN-2:0], in_bit};
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    // Only the low len bits of history and pattern take part
    hit = in_valid && (len != '0) && (fill_n >= len) &&
          (((hist_n ^ pat) & mask) == '0);
    cnt_hit = hit && !cfg_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat   <= DEFAULT_PATTERN;
      len   <= DLEN;
      ovl   <= DEFAULT_OVERLAP;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (cfg_load) begin
      pat   <= cfg_pattern;
      len   <= len_c;
      ovl   <= cfg_overlap;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (in_valid) begin
      hist  <= hist_n;
      match <= hit;
      // Non-overlap mode restarts the fill so matched bits are not reused
      fill  <= (hit && !ovl) ? '0 : fill_n;
    end else begin
      match <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_count <= '0;
    end else if (clr_count) begin
      match_count <= '0;
    end else if (cnt_hit && match_count != CMAX) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param.
// Second instance with a 2-bit counter covers saturation.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       in_bit;
  logic       clr_count;
  logic       match;
  logic [7:0] match_count;
  logic       match2;
  logic [1:0] match_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .clr_count(clr_count),
    .match(match), .match_count(match_count)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .clr_count(clr_count),
    .match(match2), .match_count(match_count2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic b,
                      input logic c);
    in_valid  = v;
    in_bit    = b;
    clr_count = c;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                     input logic o);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    in_valid    = 1'b1;
    in_bit      = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  // bits are sent MSB first; m[k] holds match after bits[k]
  task automatic run(input logic [15:0] bits, input int n,
                     output logic [15:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], 1'b0);
      m[n-1-i] = match;
    end
  endtask

  logic [15:0] m;
  logic [15:0] pat4;
  logic [15:0] idle_m;

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 1'b0; in_valid = 1'b0;
    in_bit = 1'b0; clr_count = 1'b0;
    do_reset();
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);

    run(16'b1011010110, 10, m);
    check("def_stream_m", 32'(m), 32'b0000100001);
    check("def_stream_cnt", 32'(match_count), 32'd2);
    check("def_stream_cnt2", 32'(match_count2), 32'd2);

    do_reset();
    run(16'b10110110, 8, m);
    check("nonovl_m", 32'(m), 32'b00001000);
    check("nonovl_cnt", 32'(match_count), 32'd1);
    cfg(8'b0001_0110, 4'd5, 1'b1);
    check("cfg_keeps_cnt", 32'(match_count), 32'd1);
    check("cfg_clr_match", 32'(match), 32'd0);
    run(16'b10110110, 8, m);
    check("ovl_m", 32'(m), 32'b00001001);
    check("ovl_cnt", 32'(match_count), 32'd3);

    cfg(8'b0101_0111, 4'd3, 1'b1);
    run(16'b111111, 6, m);
    check("ones_ovl_m", 32'(m), 32'b001111);
    check("ones_ovl_cnt", 32'(match_count), 32'd7);
    cfg(8'b0101_0111, 4'd3, 1'b0);
    run(16'b111111, 6, m);
    check("ones_nov_m", 32'(m), 32'b001001);
    check("ones_nov_cnt", 32'(match_count), 32'd9);

    do_reset();
    pat4 = 16'b10110;
    idle_m = '0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pat4[4-i], 1'b0);
      idle_m[14-3*i] = match;
      step(1'b0, 1'b0, 1'b0);
      idle_m[13-3*i] = match;
      step(1'b0, 1'b1, 1'b0);
      idle_m[12-3*i] = match;
    end
    check("idle_m", 32'(idle_m), 32'b000000000000100);
    check("idle_cnt", 32'(match_count), 32'd1);

    do_reset();
    run(16'b1011, 4, m);
    check("pre_rst_m", 32'(m), 32'd0);
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    check("rst_mid_m", 32'(match), 32'd0);
    check("rst_mid_cnt", 32'(match_count), 32'd0);
    run(16'b1011, 4, m);
    step(1'b1, 1'b0, 1'b1);
    check("clr_hit_m", 32'(match), 32'd1);
    check("clr_hit_cnt", 32'(match_count), 32'd0);

    cfg(8'h00, 4'd0, 1'b1);
    run(16'b0000000011111111, 16, m);
    check("len0_m_a", 32'(m), 32'd0);
    run(16'b1011010110110100, 16, m);
    check("len0_m_b", 32'(m), 32'd0);
    check("len0_cnt", 32'(match_count), 32'd0);
    cfg(8'hA5, 4'd12, 1'b0);
    run(16'b10100101, 8, m);
    check("len12_m", 32'(m), 32'b00000001);
    check("len12_cnt", 32'(match_count), 32'd1);

    step(1'b0, 1'b0, 1'b1);
    check("clr_cnt", 32'(match_count), 32'd0);
    check("clr_cnt2", 32'(match_count2), 32'd0);
    cfg(8'h07, 4'd3, 1'b1);
    run(16'b1111111, 7, m);
    check("sat_m", 32'(m), 32'b0011111);
    check("sat_cnt8", 32'(match_count), 32'd5);
    check("sat_cnt2", 32'(match_count2), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
